// File: rtl/quad_enc_decoder.sv
// quad_enc_decoder
//   Quadrature rotary-encoder front end. The asynchronous A/B phases are
//   synchronised and, optionally, stability-filtered. Gray-code transitions
//   are decoded into signed sub-steps, and those sub-steps are accumulated
//   per mechanical detent. One single-cycle INC_EN/DEC_EN strobe is emitted
//   for each completed detent. Double-phase jumps set a sticky ERR flag.
//
//   Build option: define QUAD_ENC_DECODER_FILTER_EN to include the stability
//   filter. With the filter, a new A/B value must hold for FILTER_LEN
//   consecutive CE samples before it is accepted.
//
// Parameters
//   STEPS_PER_DETENT  sub-steps per strobe (1, 2 or 4)
//   FILTER_LEN        consecutive CE samples needed to accept (2..15, filter build)
//
// Ports
//   CLK      system clock, rising edge
//   CLR_N    asynchronous active-low reset
//   CE       sample enable; decoding advances only when high
//   ENC_A    encoder phase A (asynchronous)
//   ENC_B    encoder phase B (asynchronous)
//   ERR_CLR  clears ERR (a same-cycle illegal transition wins)
//   INC_EN   one-CLK pulse per clockwise detent
//   DEC_EN   one-CLK pulse per counter-clockwise detent
//   ERR      sticky illegal-transition flag
module quad_enc_decoder #(
  parameter int STEPS_PER_DETENT = 4,
  parameter int FILTER_LEN       = 4
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic CE,
  input  logic ENC_A,
  input  logic ENC_B,
  input  logic ERR_CLR,
  output logic INC_EN,
  output logic DEC_EN,
  output logic ERR
);

  if (!(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4) ||
      FILTER_LEN < 2 || FILTER_LEN > 15) begin : gBadParams
    $error("quad_enc_decoder: illegal STEPS_PER_DETENT or FILTER_LEN");
  end

  localparam logic signed [3:0] AccMax = 4'(STEPS_PER_DETENT - 1);
  localparam logic signed [3:0] AccMin = -AccMax;

  // Position of a phase code along the clockwise cycle 00->01->11->10.
  function automatic logic [1:0] grayPos(input logic [1:0] code);
    return {code[1], code[1] ^ code[0]};
  endfunction

  logic [1:0]        syncA_q, syncB_q;
  logic [1:0]        syncVal;
  logic [1:0]        fill_q, fill_d;
  logic              primed_q, primed_d;
  logic [1:0]        prev_q, prev_d;
  logic [1:0]        cur;
  logic [1:0]        posDelta;
  logic signed [3:0] acc_q, acc_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              err_q, err_d;
  logic              sampleEn;
`ifdef QUAD_ENC_DECODER_FILTER_EN
  logic [1:0]        filt_q, filt_d;
  logic [1:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
`endif

  assign syncVal = {syncA_q[1], syncB_q[1]};

  // The synchroniser flops reset to 0. They need two edges after reset
  // before they hold real input samples. Priming waits for that fill, so a
  // phase held at 11 through reset is not mistaken for a 00->11 jump.
  assign sampleEn = CE && fill_q[1];

  always_comb begin
    fill_d = fill_q[1] ? fill_q : fill_q + 2'd1;
  end

  // Main decode: optional filter, Gray step decode, detent accumulator,
  // strobe generation and the sticky error flag.
  always_comb begin
    primed_d = primed_q;
    prev_d   = prev_q;
    acc_d    = acc_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    err_d    = err_q;
    cur      = prev_q;
    posDelta = 2'd0;
`ifdef QUAD_ENC_DECODER_FILTER_EN
    filt_d   = filt_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
`endif

    if (ERR_CLR) begin
      err_d = 1'b0;
    end

    if (sampleEn) begin
      if (!primed_q) begin
        primed_d = 1'b1;
        prev_d   = syncVal;
`ifdef QUAD_ENC_DECODER_FILTER_EN
        filt_d   = syncVal;
        cand_d   = syncVal;
        cnt_d    = 4'd0;
`endif
      end else begin
`ifdef QUAD_ENC_DECODER_FILTER_EN
        // A change of candidate restarts the run count. The filtered value
        // is decoded one sample after it is accepted.
        cur = filt_q;
        if (syncVal == filt_q) begin
          cnt_d = 4'd0;
        end else if (syncVal != cand_q) begin
          cand_d = syncVal;
          cnt_d  = 4'd1;
        end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
          filt_d = syncVal;
          cnt_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`else
        cur = syncVal;
`endif
        posDelta = grayPos(cur) - grayPos(prev_q);
        prev_d   = cur;
        case (posDelta)
          2'd1: begin
            if (acc_q == AccMax) begin
              inc_d = 1'b1;
              acc_d = '0;
            end else begin
              acc_d = acc_q + 4'sd1;
            end
          end
          2'd3: begin
            if (acc_q == AccMin) begin
              dec_d = 1'b1;
              acc_d = '0;
            end else begin
              acc_d = acc_q - 4'sd1;
            end
          end
          2'd2: begin
            err_d = 1'b1;
            acc_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // The synchroniser runs on every clock. All other state advances through
  // the next-state logic above.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      syncA_q  <= '0;
      syncB_q  <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      prev_q   <= '0;
      acc_q    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef QUAD_ENC_DECODER_FILTER_EN
      filt_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      syncA_q  <= {syncA_q[0], ENC_A};
      syncB_q  <= {syncB_q[0], ENC_B};
      fill_q   <= fill_d;
      primed_q <= primed_d;
      prev_q   <= prev_d;
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      err_q    <= err_d;
`ifdef QUAD_ENC_DECODER_FILTER_EN
      filt_q   <= filt_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign INC_EN = inc_q;
  assign DEC_EN = dec_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_quad_enc_decoder.sv
// tb_quad_enc_decoder
//   Scoreboard bench for quad_enc_decoder. A reference model tracks the
//   mechanical position (0..3 around the Gray cycle) and the detent count.
//   Each step pushes the expected strobe and its arrival edge into a queue.
//   A negedge monitor pops one entry for every strobe the DUT presents.
module tb_quad_enc_decoder;

  localparam int S  = 4;
  localparam int FL = 4;
`ifdef QUAD_ENC_DECODER_FILTER_EN
  localparam int  Lat       = FL + 3;
  localparam bit  FiltBuild = 1'b1;
`else
  localparam int  Lat       = 3;
  localparam bit  FiltBuild = 1'b0;
`endif

  logic CLK = 1'b0;
  logic CLR_N, CE, ENC_A, ENC_B, ERR_CLR;
  logic INC_EN, DEC_EN, ERR;

  quad_enc_decoder #(.STEPS_PER_DETENT(S), .FILTER_LEN(FL)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .ENC_A(ENC_A), .ENC_B(ENC_B),
    .ERR_CLR(ERR_CLR), .INC_EN(INC_EN), .DEC_EN(DEC_EN), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int edgeCnt = 0;
  always @(posedge CLK) edgeCnt++;

  typedef struct {
    bit isInc;
    int atEdge;
  } exp_t;
  exp_t expQ[$];

  int checks = 0;
  int passes = 0;

  // Reference model: physical position, detent count and error flag.
  int   modelPos = 0;
  int   modelAcc = 0;
  bit   modelErr = 1'b0;
  logic [1:0] codeOf [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: each strobe must match the head of the expected queue, in
  // direction and in arrival edge.
  always @(negedge CLK) begin
    exp_t e;
    if (INC_EN && DEC_EN) checkOutput("inc_dec_together", 1, 0);
    if (INC_EN || DEC_EN) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("strobe_dir_inc", int'(INC_EN), int'(e.isInc));
        checkOutput("strobe_edge", edgeCnt, e.atEdge);
      end
    end
  end

  // One encoder move: delta +1/-1 = legal step, 2 = illegal jump, 0 = hold.
  // clrMode 1 pulses ERR_CLR before the move. clrMode 2 pulses ERR_CLR on
  // the very edge that decodes the move.
  task automatic applyStimulus(input int delta, input int hold, input int clrMode);
    int newPos;
    int changeEdge;
    if (clrMode == 1) begin
      @(posedge CLK); #1 ERR_CLR = 1'b1;
      modelErr = 1'b0;
      @(posedge CLK); #1 ERR_CLR = 1'b0;
    end else begin
      @(posedge CLK); #1;
    end
    newPos = (modelPos + delta + 4) % 4;
    {ENC_A, ENC_B} = codeOf[newPos];
    changeEdge = edgeCnt;
    if (CE) begin
      if (delta == 2) begin
        modelErr = 1'b1;
        modelAcc = 0;
      end else if (delta != 0) begin
        modelAcc += delta;
        if (modelAcc == S) begin
          expQ.push_back('{1'b1, changeEdge + Lat});
          modelAcc = 0;
        end else if (modelAcc == -S) begin
          expQ.push_back('{1'b0, changeEdge + Lat});
          modelAcc = 0;
        end
      end
    end
    modelPos = newPos;
    if (clrMode == 2) begin
      repeat (Lat - 1) @(posedge CLK);
      #1 ERR_CLR = 1'b1;
      @(posedge CLK); #1 ERR_CLR = 1'b0;
      repeat (hold - Lat - 1) @(posedge CLK);
    end else begin
      repeat (hold - 1) @(posedge CLK);
    end
  endtask

  task automatic steps(input int delta, input int n);
    for (int i = 0; i < n; i++) applyStimulus(delta, 10, 0);
  endtask

  task automatic checkIdle(input string name);
    repeat (Lat + 2) @(posedge CLK);
    #1;
    checkOutput(name, expQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    CLR_N = 1'b0; CE = 1'b1; ERR_CLR = 1'b0;
    {ENC_A, ENC_B} = 2'b11;
    modelPos = 2;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_inc", int'(INC_EN), 0);
    checkOutput("reset_dec", int'(DEC_EN), 0);
    checkOutput("reset_err", int'(ERR), 0);

    // Release with 11 held: priming gives no step and no error.
    CLR_N = 1'b1;
    repeat (50) @(posedge CLK);
    #1;
    checkOutput("prime_err", int'(ERR), 0);
    checkOutput("prime_no_strobe", expQ.size(), 0);

    // Illegal 11->00, then a half detent, then reset mid-detent.
    applyStimulus(2, 10, 0);
    checkOutput("illegal_err", int'(ERR), 1);
    steps(1, 2);
    CLR_N = 1'b0;
    {ENC_A, ENC_B} = 2'b00;
    modelPos = 0; modelAcc = 0; modelErr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("midreset_inc", int'(INC_EN), 0);
    checkOutput("midreset_dec", int'(DEC_EN), 0);
    checkOutput("midreset_err", int'(ERR), 0);
    CLR_N = 1'b1;
    repeat (6) @(posedge CLK);

    // Full clockwise and counter-clockwise detents.
    steps(1, 4);
    checkIdle("cw_detent_done");
    steps(-1, 4);
    checkIdle("ccw_detent_done");

    // Reversal: no strobe. Then one full detent.
    steps(1, 3);
    steps(-1, 3);
    checkIdle("reversal_no_strobe");
    steps(1, 4);
    checkIdle("after_reversal");

    // Illegal jump clears the accumulator; then ERR_CLR behaviour.
    steps(1, 2);
    applyStimulus(2, 10, 0);
    checkOutput("jump_err", int'(ERR), 1);
    steps(1, 4);
    checkIdle("after_jump_detent");
    @(posedge CLK); #1 ERR_CLR = 1'b1;
    modelErr = 1'b0;
    @(posedge CLK); #1 ERR_CLR = 1'b0;
    checkOutput("err_clr", int'(ERR), 0);
    applyStimulus(2, 12, 2);
    checkOutput("err_set_wins", int'(ERR), 1);
    applyStimulus(0, 10, 1);
    checkOutput("err_clr_again", int'(ERR), 0);

    // A 2-sample glitch at acc=3: filtered away, or a +1/-1 pair.
    steps(1, 3);
    if (FiltBuild) begin
      @(posedge CLK); #1 {ENC_A, ENC_B} = codeOf[(modelPos + 1) % 4];
      @(posedge CLK); @(posedge CLK); #1 {ENC_A, ENC_B} = codeOf[modelPos];
      repeat (10) @(posedge CLK);
    end else begin
      applyStimulus(1, 2, 0);
      applyStimulus(-1, 10, 0);
    end
    checkIdle("glitch");

    // CE low through a full detent: frozen, no strobe, accumulator kept.
    CE = 1'b0;
    steps(1, 4);
    CE = 1'b1;
    checkIdle("ce_low_detent");

    // Randomised walk against the model.
    for (int i = 0; i < 150; i++) begin
      int r;
      int d;
      r = $urandom_range(0, 19);
      d = (r < 9) ? 1 : (r < 17) ? -1 : (r < 18) ? 0 : 2;
      applyStimulus(d, $urandom_range(10, 14), ($urandom_range(0, 5) == 0) ? 1 : 0);
      checkOutput("rand_err", int'(ERR), int'(modelErr));
    end
    checkIdle("final_queue_empty");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
